// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures decoded control, operands and instruction fields for EX, inserts
// a marked bubble on a load-use dependency, and honours flush and hold.
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [6:0]       muxctrl_in,
  input  logic [2:0]       memctrl_in,
  input  logic [4:0]       aluctrl_in,
  input  logic [DW-1:0]    rd1_in,
  input  logic [DW-1:0]    rd2_in,
  input  logic [DW-1:0]    imm_in,
  input  logic [DW-1:0]    pc_in,
  input  logic [4:0]       shamt_in,
  input  logic [4:0]       rs_in,
  input  logic [4:0]       rt_in,
  input  logic [4:0]       rd_in,
  input  logic             flush,
  input  logic             hold,
  output logic [6:0]       muxctrl_ex,
  output logic [2:0]       memctrl_ex,
  output logic [4:0]       aluctrl_ex,
  output logic [DW-1:0]    rd1_ex,
  output logic [DW-1:0]    rd2_ex,
  output logic [DW-1:0]    imm_ex,
  output logic [DW-1:0]    pc_ex,
  output logic [4:0]       shamt_ex,
  output logic [4:0]       rs_ex,
  output logic [4:0]       rt_ex,
  output logic [4:0]       dest_ex,
  output logic             ex_valid,
  output logic             stall_if_id,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Handshake: there is no valid/ready pair here; id_valid qualifies the ID
  // slot, stall_if_id tells IF/ID to hold its contents this cycle, and hold
  // freezes this register entirely while downstream memory is busy.

  logic [6:0]       r_muxctrl;
  logic [2:0]       r_memctrl;
  logic [4:0]       r_aluctrl;
  logic [DW-1:0]    r_rd1;
  logic [DW-1:0]    r_rd2;
  logic [DW-1:0]    r_imm;
  logic [DW-1:0]    r_pc;
  logic [4:0]       r_shamt;
  logic [4:0]       r_rs;
  logic [4:0]       r_rt;
  logic [4:0]       r_dest;
  logic             r_valid;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic [4:0]       w_dest;
  logic             w_load_use;
  logic             w_cnt_full;

  // Decode the write-back register index before it is latched
  always_comb begin
    w_dest = rd_in;
    unique case (muxctrl_in[3:2])
      2'b00:   w_dest = rd_in;
      2'b01:   w_dest = rt_in;
      2'b10:   w_dest = 5'd31;
      default: w_dest = 5'd0;
    endcase
  end

  // Load in EX whose destination is read by the instruction now in ID
  always_comb begin
    w_load_use = r_valid & r_memctrl[2] & (r_dest != 5'd0) & id_valid &
                 ((r_dest == rs_in) | (r_dest == rt_in));
    w_cnt_full = &r_bubble_cnt;
    stall_if_id = ~reset & (hold | (w_load_use & ~flush));
  end

  // Pipeline register update: hold > flush > load-use bubble > normal load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_muxctrl    <= '0;
      r_memctrl    <= '0;
      r_aluctrl    <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_pc         <= '0;
      r_shamt      <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_dest       <= '0;
      r_valid      <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (hold) begin
      r_valid <= r_valid;
    end else if (flush || w_load_use) begin
      // Bubble: nothing writes registers or memory; only a load-use bubble
      // carries the marker bit and is counted.
      r_muxctrl <= w_load_use && !flush ? 7'b001_0000 : 7'b000_0000;
      r_memctrl <= '0;
      r_aluctrl <= '0;
      r_rd1     <= '0;
      r_rd2     <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_shamt   <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_dest    <= '0;
      r_valid   <= 1'b0;
      if (!flush && !w_cnt_full) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end else begin
      r_muxctrl <= id_valid ? muxctrl_in : 7'b0;
      r_memctrl <= id_valid ? memctrl_in : 3'b0;
      r_aluctrl <= id_valid ? aluctrl_in : 5'b0;
      r_rd1     <= rd1_in;
      r_rd2     <= rd2_in;
      r_imm     <= imm_in;
      r_pc      <= pc_in;
      r_shamt   <= shamt_in;
      r_rs      <= rs_in;
      r_rt      <= rt_in;
      r_dest    <= w_dest;
      r_valid   <= id_valid;
    end
  end

  assign muxctrl_ex = r_muxctrl;
  assign memctrl_ex = r_memctrl;
  assign aluctrl_ex = r_aluctrl;
  assign rd1_ex     = r_rd1;
  assign rd2_ex     = r_rd2;
  assign imm_ex     = r_imm;
  assign pc_ex      = r_pc;
  assign shamt_ex   = r_shamt;
  assign rs_ex      = r_rs;
  assign rt_ex      = r_rt;
  assign dest_ex    = r_dest;
  assign ex_valid   = r_valid;
  assign bubble_cnt = r_bubble_cnt;

endmodule
